// File: rtl/cache_wb_ctrl.sv
// -----------------------------------------------------------------------------
// cache_wb_ctrl
//
// Dirty-line writeback controller for the data cache. On an eviction request it
// looks up the victim's dirty bit and tag. A clean victim finishes at once. A
// dirty victim is streamed word by word from the data RAM to memory over a
// valid/ready write channel. The controller then waits for the write response,
// clears the dirty bit and reports completion.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   evict_req_i       eviction request, taken only while evict_ready_o=1
//   evict_index_i     victim index
//   evict_ready_o     controller idle
//   evict_done_o      one-cycle completion pulse
//   evict_wb_o        with evict_done_o: 1 = line was written back
//   dirty_index_o     registered index to the dirty and tag RAMs
//   dirty_rd_dirty_i  dirty bit for dirty_index_o
//   tag_i             tag for dirty_index_o
//   dirty_wr_en_o     dirty-table write strobe (single cycle)
//   dirty_wr_dirty_o  dirty-table write data, always 0
//   data_rd_addr_o    data RAM word address {index, offset}
//   data_rd_i         data RAM word for data_rd_addr_o
//   mem_w*            memory write beat channel (valid/ready, last marks end)
//   mem_bvalid_i      memory write response
//
// The RAM read data inputs are expected one cycle after the controller
// registers the address. They are sampled at the end of the cycle in which the
// registered address is presented.
// The widths must satisfy TAG_W + CACHE_INDEX_AW + OFF_W + 2 = 32.
// -----------------------------------------------------------------------------
module cache_wb_ctrl #(
    parameter int  CACHE_INDEX_AW = 8,
    parameter int  TAG_W          = 20,
    parameter int  LINE_WORDS     = 4,
    parameter int  DATA_W         = 32,
    localparam int OFF_W          = $clog2(LINE_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        evict_req_i,
    input  logic [CACHE_INDEX_AW-1:0]   evict_index_i,
    output logic                        evict_ready_o,
    output logic                        evict_done_o,
    output logic                        evict_wb_o,
    output logic [CACHE_INDEX_AW-1:0]   dirty_index_o,
    input  logic                        dirty_rd_dirty_i,
    input  logic [TAG_W-1:0]            tag_i,
    output logic                        dirty_wr_en_o,
    output logic                        dirty_wr_dirty_o,
    output logic [CACHE_INDEX_AW+OFF_W-1:0] data_rd_addr_o,
    input  logic [DATA_W-1:0]           data_rd_i,
    output logic                        mem_wvalid_o,
    input  logic                        mem_wready_i,
    output logic [31:0]                 mem_waddr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    output logic                        mem_wlast_o,
    input  logic                        mem_bvalid_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RD,
        S_SEND,
        S_RESP,
        S_CLEAR,
        S_DONE
    } state_e;

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

    state_e                    state_q;
    logic [CACHE_INDEX_AW-1:0] index_q;
    logic [TAG_W-1:0]          tag_q;
    logic [OFF_W-1:0]          off_q;
    logic [DATA_W-1:0]         wdata_q;
    logic                      ready_q;
    logic                      done_q;
    logic                      wb_q;
    logic                      wr_en_q;
    logic                      wvalid_q;
    logic                      wlast_q;

    // NOTE: every register below is updated with non-blocking assignments so
    // that all of them sample the pre-edge values of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            tag_q    <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            wb_q     <= 1'b0;
            wr_en_q  <= 1'b0;
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // The index is frozen here until the next IDLE.
                    if (evict_req_i) begin
                        index_q <= evict_index_i;
                        ready_q <= 1'b0;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    tag_q <= tag_i;
                    if (dirty_rd_dirty_i) begin
                        off_q   <= '0;
                        state_q <= S_RD;
                    end else begin
                        done_q  <= 1'b1;
                        wb_q    <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_RD: begin
                    // The data RAM presents the word for {index, offset} now.
                    wdata_q  <= data_rd_i;
                    wvalid_q <= 1'b1;
                    wlast_q  <= (off_q == LAST_OFF);
                    state_q  <= S_SEND;
                end
                S_SEND: begin
                    // The valid signal is always high in this state, so the
                    // ready signal alone completes the beat.
                    if (mem_wready_i) begin
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                        if (wlast_q) begin
                            state_q <= S_RESP;
                        end else begin
                            off_q   <= off_q + OFF_W'(1);
                            state_q <= S_RD;
                        end
                    end
                end
                S_RESP: begin
                    if (mem_bvalid_i) begin
                        wr_en_q <= 1'b1;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b1;
                    wb_q    <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    wb_q    <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    ready_q  <= 1'b1;
                    done_q   <= 1'b0;
                    wb_q     <= 1'b0;
                    wr_en_q  <= 1'b0;
                    wvalid_q <= 1'b0;
                    wlast_q  <= 1'b0;
                end
            endcase
        end
    end

    assign evict_ready_o    = ready_q;
    assign evict_done_o     = done_q;
    assign evict_wb_o       = wb_q;
    assign dirty_index_o    = index_q;
    assign dirty_wr_en_o    = wr_en_q;
    assign dirty_wr_dirty_o = 1'b0;
    assign data_rd_addr_o   = {index_q, off_q};
    assign mem_wvalid_o     = wvalid_q;
    assign mem_waddr_o      = {tag_q, index_q, off_q, 2'b00};
    assign mem_wdata_o      = wdata_q;
    assign mem_wlast_o      = wlast_q;

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_wb_ctrl
//
// Bench for cache_wb_ctrl. The dirty, tag and data RAMs are behavioural arrays.
// Each eviction has its ready and response inputs pre-generated for every
// cycle. From those inputs a cycle timeline is computed from the protocol
// rules: beat k valid from its start cycle until accepted, next beat two
// cycles later, response counted only after the last beat, then clear, then
// done. Every output is compared against that timeline on every cycle.
// -----------------------------------------------------------------------------
module tb_cache_wb_ctrl;

    localparam int AW   = 8;
    localparam int TW   = 20;
    localparam int LW   = 4;
    localparam int DW   = 32;
    localparam int OW   = 2;
    localparam int MAXC = 96;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              evict_req_i;
    logic [AW-1:0]     evict_index_i;
    logic              evict_ready_o;
    logic              evict_done_o;
    logic              evict_wb_o;
    logic [AW-1:0]     dirty_index_o;
    logic              dirty_rd_dirty_i;
    logic [TW-1:0]     tag_i;
    logic              dirty_wr_en_o;
    logic              dirty_wr_dirty_o;
    logic [AW+OW-1:0]  data_rd_addr_o;
    logic [DW-1:0]     data_rd_i;
    logic              mem_wvalid_o;
    logic              mem_wready_i;
    logic [31:0]       mem_waddr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic              mem_wlast_o;
    logic              mem_bvalid_i;

    bit            dirty_mem [2**AW];
    logic [TW-1:0] tag_mem   [2**AW];
    logic [DW-1:0] data_mem  [2**(AW+OW)];
    bit            wr_seq    [MAXC];
    bit            bv_seq    [MAXC];

    int n_checks = 0;
    int n_fail   = 0;

    cache_wb_ctrl #(
        .CACHE_INDEX_AW(AW),
        .TAG_W         (TW),
        .LINE_WORDS    (LW),
        .DATA_W        (DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .evict_req_i     (evict_req_i),
        .evict_index_i   (evict_index_i),
        .evict_ready_o   (evict_ready_o),
        .evict_done_o    (evict_done_o),
        .evict_wb_o      (evict_wb_o),
        .dirty_index_o   (dirty_index_o),
        .dirty_rd_dirty_i(dirty_rd_dirty_i),
        .tag_i           (tag_i),
        .dirty_wr_en_o   (dirty_wr_en_o),
        .dirty_wr_dirty_o(dirty_wr_dirty_o),
        .data_rd_addr_o  (data_rd_addr_o),
        .data_rd_i       (data_rd_i),
        .mem_wvalid_o    (mem_wvalid_o),
        .mem_wready_i    (mem_wready_i),
        .mem_waddr_o     (mem_waddr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wlast_o     (mem_wlast_o),
        .mem_bvalid_i    (mem_bvalid_i)
    );

    always #5 clk = ~clk;

    // RAM read ports: data follows the registered address the controller drives.
    assign dirty_rd_dirty_i = dirty_mem[dirty_index_o];
    assign tag_i            = tag_mem[dirty_index_o];
    assign data_rd_i        = data_mem[data_rd_addr_o];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock. The dirty-table write lands at the edge, as a RAM would.
    task automatic tick();
        if (dirty_wr_en_o) dirty_mem[dirty_index_o] = dirty_wr_dirty_o;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".ready"},    64'(evict_ready_o),    64'd1);
        check({tag, ".done"},     64'(evict_done_o),     64'd0);
        check({tag, ".wb"},       64'(evict_wb_o),       64'd0);
        check({tag, ".index"},    64'(dirty_index_o),    64'd0);
        check({tag, ".wr_en"},    64'(dirty_wr_en_o),    64'd0);
        check({tag, ".wr_dirty"}, 64'(dirty_wr_dirty_o), 64'd0);
        check({tag, ".rd_addr"},  64'(data_rd_addr_o),   64'd0);
        check({tag, ".wvalid"},   64'(mem_wvalid_o),     64'd0);
        check({tag, ".waddr"},    64'(mem_waddr_o),      64'd0);
        check({tag, ".wdata"},    64'(mem_wdata_o),      64'd0);
        check({tag, ".wlast"},    64'(mem_wlast_o),      64'd0);
    endtask

    task automatic fill_ideal();
        for (int c = 0; c < MAXC; c++) begin
            wr_seq[c] = 1'b1;
            bv_seq[c] = 1'b0;
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < MAXC; c++) begin
            wr_seq[c] = (c >= 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
            bv_seq[c] = (c >= 60) ? 1'b1 : ($urandom_range(0, 3) == 0);
        end
    endtask

    // One eviction, starting in an idle cycle (cycle 0 = request cycle). The
    // task returns in the cycle after done, or right after reset at abort_at.
    task automatic run_evict(input logic [AW-1:0] idx, input bit hold_req, input int abort_at);
        bit          d;
        int          vs  [LW];
        int          acc [LW];
        int          clr;
        int          dn;
        int          t;
        int          r;
        bit          exp_v;
        int          k_cur;
        logic [31:0] ea;

        d   = dirty_mem[idx];
        clr = -1;
        dn  = 2;
        if (d) begin
            t = 3;
            for (int k = 0; k < LW; k++) begin
                vs[k] = t;
                while (t < MAXC - 1 && !wr_seq[t]) t++;
                acc[k] = t;
                t = t + 2;
            end
            r = acc[LW-1] + 1;
            while (r < MAXC - 1 && !bv_seq[r]) r++;
            clr = r + 1;
            dn  = r + 2;
        end else begin
            for (int k = 0; k < LW; k++) begin
                vs[k]  = -1;
                acc[k] = -2;
            end
        end

        for (int c = 0; c <= dn; c++) begin
            evict_req_i   = (c == 0) ? 1'b1 : (hold_req ? 1'b1 : 1'($urandom_range(0, 1)));
            evict_index_i = (c == 0) ? idx : AW'($urandom);
            mem_wready_i  = wr_seq[c];
            mem_bvalid_i  = bv_seq[c];

            exp_v = 1'b0;
            k_cur = 0;
            for (int k = 0; k < LW; k++) begin
                if (c >= vs[k] && c <= acc[k]) begin
                    exp_v = 1'b1;
                    k_cur = k;
                end
            end

            check("ready", 64'(evict_ready_o), 64'(c == 0));
            if (c > 0) check("index", 64'(dirty_index_o), 64'(idx));
            check("done",   64'(evict_done_o),  64'(c == dn));
            check("wb",     64'(evict_wb_o),    64'((c == dn) && d));
            check("wr_en",  64'(dirty_wr_en_o), 64'(c == clr));
            if (c == clr) check("wr_dirty", 64'(dirty_wr_dirty_o), 64'd0);
            check("wvalid", 64'(mem_wvalid_o),  64'(exp_v));
            check("wlast",  64'(mem_wlast_o),   64'(exp_v && (k_cur == LW - 1)));
            if (exp_v) begin
                ea = {tag_mem[idx], idx, OW'(k_cur), 2'b00};
                check("waddr", 64'(mem_waddr_o), 64'(ea));
                check("wdata", 64'(mem_wdata_o), 64'(data_mem[{idx, OW'(k_cur)}]));
            end

            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                expect_reset("abort");
                evict_req_i  = 1'b0;
                mem_wready_i = 1'b0;
                mem_bvalid_i = 1'b0;
                #2;
                rst_n = 1'b1;
                return;
            end
            tick();
        end
        evict_req_i  = 1'b0;
        mem_wready_i = 1'b0;
        mem_bvalid_i = 1'b0;
        if (d) check("dirty_cleared", 64'(dirty_mem[idx]), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] idx;
        int            gap;

        rst_n         = 1'b0;
        evict_req_i   = 1'b0;
        evict_index_i = '0;
        mem_wready_i  = 1'b0;
        mem_bvalid_i  = 1'b0;
        for (int i = 0; i < 2**AW; i++) begin
            dirty_mem[i] = 1'($urandom_range(0, 1));
            tag_mem[i]   = TW'($urandom);
        end
        for (int i = 0; i < 2**(AW+OW); i++) data_mem[i] = $urandom;

        #12;
        expect_reset("rst");
        rst_n = 1'b1;
        tick();
        expect_reset("post_rst");

        // Clean victim: done two cycles after the request, nothing written.
        dirty_mem[8'h3A] = 1'b0;
        fill_ideal();
        run_evict(8'h3A, 1'b0, -1);
        check("clean_unchanged", 64'(dirty_mem[8'h3A]), 64'd0);

        // Dirty victim, no stalls, response at cycle 10.
        dirty_mem[8'h12] = 1'b1;
        tag_mem[8'h12]   = 20'hABCDE;
        data_mem[{8'h12, 2'd0}] = 32'h11;
        data_mem[{8'h12, 2'd1}] = 32'h22;
        data_mem[{8'h12, 2'd2}] = 32'h33;
        data_mem[{8'h12, 2'd3}] = 32'h44;
        fill_ideal();
        bv_seq[10] = 1'b1;
        run_evict(8'h12, 1'b0, -1);

        // Backpressure: beat 1 stalled for three cycles.
        dirty_mem[8'h55] = 1'b1;
        fill_ideal();
        wr_seq[5] = 1'b0;
        wr_seq[6] = 1'b0;
        wr_seq[7] = 1'b0;
        bv_seq[13] = 1'b1;
        run_evict(8'h55, 1'b0, -1);

        // Spurious responses during the burst, real one five cycles after the last beat.
        dirty_mem[8'h66] = 1'b1;
        fill_ideal();
        bv_seq[3]  = 1'b1;
        bv_seq[5]  = 1'b1;
        bv_seq[9]  = 1'b1;
        bv_seq[14] = 1'b1;
        run_evict(8'h66, 1'b0, -1);

        // Request held high: back-to-back evictions, one per done pulse.
        dirty_mem[8'h21] = 1'b1;
        dirty_mem[8'h22] = 1'b1;
        fill_random();
        run_evict(8'h21, 1'b1, -1);
        fill_random();
        run_evict(8'h22, 1'b1, -1);

        // Randomized evictions with random stalls, responses and idle gaps.
        for (int n = 0; n < 40; n++) begin
            idx = AW'($urandom);
            dirty_mem[idx] = 1'($urandom_range(0, 1));
            fill_random();
            run_evict(idx, 1'($urandom_range(0, 1)), -1);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                evict_req_i = 1'b0;
                check("gap.ready",  64'(evict_ready_o), 64'd1);
                check("gap.wvalid", 64'(mem_wvalid_o),  64'd0);
                tick();
            end
        end

        // Reset while beat 2 is in flight: beat dropped, dirty bit kept.
        dirty_mem[8'h77] = 1'b1;
        fill_ideal();
        wr_seq[7] = 1'b0;
        run_evict(8'h77, 1'b0, 7);
        check("abort.dirty_kept", 64'(dirty_mem[8'h77]), 64'd1);
        tick();
        expect_reset("after_abort");
        fill_ideal();
        bv_seq[11] = 1'b1;
        run_evict(8'h77, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
